// File: rtl/irq_inject_gen_if.sv
// Configuration bus for irq_inject_gen: one write strobe plus the per-channel
// fields that a write loads into the addressed channel.
interface irq_inject_gen_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int DLY_W  = 4,
  parameter int CNT_W  = 4
);
  logic              cfg_we;
  logic [2:0]        cfg_ch;
  logic              cfg_en;
  logic [ADDR_W-1:0] cfg_pc;
  logic [LEN_W-1:0]  cfg_len;
  logic [DLY_W-1:0]  cfg_dly;
  logic [CNT_W-1:0]  cfg_lim;

  modport master (
    output cfg_we, cfg_ch, cfg_en, cfg_pc, cfg_len, cfg_dly, cfg_lim
  );

  modport slave (
    input cfg_we, cfg_ch, cfg_en, cfg_pc, cfg_len, cfg_dly, cfg_lim
  );
endinterface

// File: rtl/irq_inject_gen.sv
// irq_inject_gen: per-channel PC-triggered interrupt pulse generator.
// Each channel fires a pulse of programmable length on irq_o[i] a programmable
// delay after the PC first lands on its trigger address, up to a fire limit.
// Optional feature macro: IRQ_INJ_ACK_EN adds the irq_ack input, which lets a
// consumer end an asserted pulse early (counted as a normal fire).
module irq_inject_gen #(
  parameter int CH     = 6,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int DLY_W  = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  irq_inject_gen_if.slave   cfg,
`ifdef IRQ_INJ_ACK_EN
  input  logic [CH-1:0]     irq_ack,
`endif
  output logic [CH-1:0]     irq_o,
  output logic              irq_any_o,
  output logic [CH-1:0]     done_o
);

  // The timer holds either a delay or a pulse length, so it is sized for the wider.
  localparam int TMR_W = (LEN_W > DLY_W) ? LEN_W : DLY_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_DELAY  = 3'd2,
    S_ASSERT = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  logic [CH-1:0] ack_w;
`ifdef IRQ_INJ_ACK_EN
  assign ack_w = irq_ack;
`else
  assign ack_w = '0;
`endif

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] trig_q, trig_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [CNT_W-1:0]  lim_q, lim_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              prev_match_q, prev_match_d;
    logic              irq_q, irq_d;
    logic              done_q, done_d;

    logic              wr;
    logic              hit;
    logic              match;
    logic [TMR_W-1:0]  len_m1;
    logic [TMR_W-1:0]  dly_m1;
    logic [CNT_W-1:0]  cnt_inc;

    assign wr    = cfg.cfg_we && (cfg.cfg_ch == 3'(gi));
    assign hit   = (pc_in == trig_q);
    // Rising-edge qualification: a PC stalled on the trigger only matches once.
    assign match = hit && !prev_match_q;
    // A zero length is treated as a one-cycle pulse.
    assign len_m1  = (len_q == '0) ? '0 : TMR_W'(len_q - LEN_W'(1));
    assign dly_m1  = TMR_W'(dly_q - DLY_W'(1));
    // Fire counter saturates rather than wrapping.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Channel state and field registers with synchronous reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q      <= S_IDLE;
        trig_q       <= '0;
        len_q        <= '0;
        dly_q        <= '0;
        lim_q        <= '0;
        cnt_q        <= '0;
        tmr_q        <= '0;
        prev_match_q <= 1'b0;
        irq_q        <= 1'b0;
        done_q       <= 1'b0;
      end else begin
        state_q      <= state_d;
        trig_q       <= trig_d;
        len_q        <= len_d;
        dly_q        <= dly_d;
        lim_q        <= lim_d;
        cnt_q        <= cnt_d;
        tmr_q        <= tmr_d;
        prev_match_q <= prev_match_d;
        irq_q        <= irq_d;
        done_q       <= done_d;
      end
    end

    // Next-state logic: a config write overrides any match or timer event.
    always_comb begin
      state_d      = state_q;
      trig_d       = trig_q;
      len_d        = len_q;
      dly_d        = dly_q;
      lim_d        = lim_q;
      cnt_d        = cnt_q;
      tmr_d        = tmr_q;
      prev_match_d = hit;
      if (wr) begin
        trig_d  = cfg.cfg_pc;
        len_d   = cfg.cfg_len;
        dly_d   = cfg.cfg_dly;
        lim_d   = cfg.cfg_lim;
        cnt_d   = '0;
        tmr_d   = '0;
        state_d = cfg.cfg_en ? S_ARMED : S_IDLE;
      end else begin
        case (state_q)
          S_ARMED: begin
            if (match) begin
              if (dly_q != '0) begin
                state_d = S_DELAY;
                tmr_d   = dly_m1;
              end else begin
                state_d = S_ASSERT;
                tmr_d   = len_m1;
              end
            end
          end
          S_DELAY: begin
            if (tmr_q == '0) begin
              state_d = S_ASSERT;
              tmr_d   = len_m1;
            end else begin
              tmr_d = tmr_q - TMR_W'(1);
            end
          end
          S_ASSERT: begin
            if (tmr_q == '0 || ack_w[gi]) begin
              cnt_d   = cnt_inc;
              tmr_d   = '0;
              state_d = (lim_q != '0 && cnt_inc == lim_q) ? S_DONE : S_ARMED;
            end else begin
              tmr_d = tmr_q - TMR_W'(1);
            end
          end
          default: ;
        endcase
      end
      // Outputs are flopped from the next state so they carry no logic from pc_in.
      irq_d  = (state_d == S_ASSERT);
      done_d = (state_d == S_DONE);
    end

    assign irq_o[gi]  = irq_q;
    assign done_o[gi] = done_q;
  end

  assign irq_any_o = |irq_o;

endmodule

// File: tb/tb_irq_inject_gen.sv
// Directed, table-driven bench for irq_inject_gen. Each record gives the inputs
// for one clock and the irq/done vectors expected just after that edge.
module tb_irq_inject_gen;
  localparam int CH = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic [5:0]  irq_ack;
  logic [5:0]  irq_o;
  logic        irq_any_o;
  logic [5:0]  done_o;

  int checks   = 0;
  int failures = 0;

  irq_inject_gen_if cfg_bus ();

  irq_inject_gen #(.CH(CH)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_in     (pc_in),
    .cfg       (cfg_bus),
`ifdef IRQ_INJ_ACK_EN
    .irq_ack   (irq_ack),
`endif
    .irq_o     (irq_o),
    .irq_any_o (irq_any_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [2:0]  ch;
    logic        en;
    logic [31:0] trig;
    logic [3:0]  len;
    logic [3:0]  dly;
    logic [3:0]  lim;
    logic [31:0] pc;
    logic [5:0]  ack;
    logic [5:0]  eirq;
    logic [5:0]  edone;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic we, logic [2:0] ch, logic en,
                              logic [31:0] trig, logic [3:0] len, logic [3:0] dly,
                              logic [3:0] lim, logic [31:0] pc, logic [5:0] ack,
                              logic [5:0] eirq, logic [5:0] edone);
    vec_t v;
    v.rst = rst; v.we = we; v.ch = ch; v.en = en; v.trig = trig;
    v.len = len; v.dly = dly; v.lim = lim; v.pc = pc; v.ack = ack;
    v.eirq = eirq; v.edone = edone;
    return v;
  endfunction

  function automatic void row_pc(logic [31:0] pc, logic [5:0] eirq, logic [5:0] edone);
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 4'd0, 4'd0, 4'd0, pc, 6'd0, eirq, edone));
  endfunction

  function automatic void row_cfg(logic [2:0] ch, logic en, logic [31:0] trig,
                                  logic [3:0] len, logic [3:0] dly, logic [3:0] lim,
                                  logic [31:0] pc, logic [5:0] eirq, logic [5:0] edone);
    vecs.push_back(mk(1'b0, 1'b1, ch, en, trig, len, dly, lim, pc, 6'd0, eirq, edone));
  endfunction

  function automatic void row_rst(logic [31:0] pc);
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 4'd0, 4'd0, 4'd0, pc, 6'd0, 6'd0, 6'd0));
  endfunction

  task automatic check6(string nm, int idx, logic [5:0] act, logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
    end
  endtask

  // Drive one record, let one edge consume it, then compare outputs.
  task automatic apply(string tag, int idx, vec_t v);
    reset           = v.rst;
    cfg_bus.cfg_we  = v.we;
    cfg_bus.cfg_ch  = v.ch;
    cfg_bus.cfg_en  = v.en;
    cfg_bus.cfg_pc  = v.trig;
    cfg_bus.cfg_len = v.len;
    cfg_bus.cfg_dly = v.dly;
    cfg_bus.cfg_lim = v.lim;
    pc_in           = v.pc;
    irq_ack         = v.ack;
    @(posedge clk);
    #1;
    check6({tag, ".irq"}, idx, irq_o, v.eirq);
    check6({tag, ".any"}, idx, {5'd0, irq_any_o}, {5'd0, |v.eirq});
    check6({tag, ".done"}, idx, done_o, v.edone);
    $display("step %s/%0d pc=%h we=%0d ch=%0d irq=%b any=%0d done=%b",
             tag, idx, v.pc, v.we, v.ch, irq_o, irq_any_o, done_o);
  endtask

  initial begin
    reset = 1'b1;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_ch = 3'd0; cfg_bus.cfg_en = 1'b0;
    cfg_bus.cfg_pc = 32'h0; cfg_bus.cfg_len = 4'd0; cfg_bus.cfg_dly = 4'd0;
    cfg_bus.cfg_lim = 4'd0;
    pc_in = 32'h100;
    irq_ack = 6'd0;

    // Reset state.
    row_rst(32'h100);
    // ch0: len 6, dly 0, lim 1 -> six high cycles, then DONE, revisit ignored.
    row_cfg(3'd0, 1'b1, 32'h3024, 4'd6, 4'd0, 4'd1, 32'h100, 6'b000000, 6'b000000);
    row_pc(32'h3024, 6'b000001, 6'b000000);
    for (int i = 0; i < 5; i++) row_pc(32'h100, 6'b000001, 6'b000000);
    row_pc(32'h100,  6'b000000, 6'b000001);
    row_pc(32'h3024, 6'b000000, 6'b000001);
    row_pc(32'h100,  6'b000000, 6'b000001);
    // ch1: len 2, dly 3, unlimited; 5-cycle stall then a revisit -> two pulses.
    row_cfg(3'd1, 1'b1, 32'h4198, 4'd2, 4'd3, 4'd0, 32'h100, 6'b000000, 6'b000001);
    for (int i = 0; i < 3; i++) row_pc(32'h4198, 6'b000000, 6'b000001);
    row_pc(32'h4198, 6'b000010, 6'b000001);
    row_pc(32'h4198, 6'b000010, 6'b000001);
    row_pc(32'h100,  6'b000000, 6'b000001);
    row_pc(32'h4198, 6'b000000, 6'b000001);
    row_pc(32'h100,  6'b000000, 6'b000001);
    row_pc(32'h100,  6'b000000, 6'b000001);
    row_pc(32'h100,  6'b000010, 6'b000001);
    row_pc(32'h100,  6'b000010, 6'b000001);
    row_pc(32'h100,  6'b000000, 6'b000001);
    // ch2: len 0 -> one-cycle pulse.
    row_cfg(3'd2, 1'b1, 32'h5000, 4'd0, 4'd0, 4'd0, 32'h100, 6'b000000, 6'b000001);
    row_pc(32'h5000, 6'b000100, 6'b000001);
    row_pc(32'h100,  6'b000000, 6'b000001);
    // ch2: len 4, disabling write mid-pulse drops irq and leaves it IDLE.
    row_cfg(3'd2, 1'b1, 32'h5000, 4'd4, 4'd0, 4'd0, 32'h100, 6'b000000, 6'b000001);
    row_pc(32'h5000, 6'b000100, 6'b000001);
    row_pc(32'h100,  6'b000100, 6'b000001);
    row_cfg(3'd2, 1'b0, 32'h5000, 4'd4, 4'd0, 4'd0, 32'h100, 6'b000000, 6'b000001);
    row_pc(32'h5000, 6'b000000, 6'b000001);
    row_pc(32'h100,  6'b000000, 6'b000001);
    // ch0 and ch3 share trigger 0x3000, len 3; rewriting ch0 clears its DONE.
    row_cfg(3'd0, 1'b1, 32'h3000, 4'd3, 4'd0, 4'd0, 32'h100, 6'b000000, 6'b000000);
    row_cfg(3'd3, 1'b1, 32'h3000, 4'd3, 4'd0, 4'd0, 32'h100, 6'b000000, 6'b000000);
    row_pc(32'h3000, 6'b001001, 6'b000000);
    row_pc(32'h100,  6'b001001, 6'b000000);
    row_pc(32'h100,  6'b001001, 6'b000000);
    row_pc(32'h100,  6'b000000, 6'b000000);
    // Out-of-range channel write changes nothing.
    row_cfg(3'd7, 1'b0, 32'h0, 4'd0, 4'd0, 4'd0, 32'h100, 6'b000000, 6'b000000);
    row_pc(32'h3000, 6'b001001, 6'b000000);
    row_pc(32'h100,  6'b001001, 6'b000000);
    row_pc(32'h100,  6'b001001, 6'b000000);
    row_pc(32'h100,  6'b000000, 6'b000000);
    // ch5 to DONE, then reset during ch4 ASSERT clears everything.
    row_cfg(3'd5, 1'b1, 32'h7000, 4'd1, 4'd0, 4'd1, 32'h100, 6'b000000, 6'b000000);
    row_pc(32'h7000, 6'b100000, 6'b000000);
    row_pc(32'h100,  6'b000000, 6'b100000);
    row_cfg(3'd4, 1'b1, 32'h6000, 4'd5, 4'd0, 4'd0, 32'h100, 6'b000000, 6'b100000);
    row_pc(32'h6000, 6'b010000, 6'b100000);
    row_pc(32'h100,  6'b010000, 6'b100000);
    row_rst(32'h100);
    row_pc(32'h6000, 6'b000000, 6'b000000);
    row_pc(32'h3000, 6'b000000, 6'b000000);
    row_pc(32'h7000, 6'b000000, 6'b000000);

    for (int i = 0; i < vecs.size(); i++) apply("tbl", i, vecs[i]);

    // Write on the same edge as a would-be match: the write wins, and the
    // stalled PC does not match afterwards until it leaves and returns.
    begin
      vec_t s[7];
      s[0] = mk(1'b0, 1'b1, 3'd2, 1'b1, 32'h5000, 4'd2, 4'd0, 4'd0, 32'h100,  6'd0, 6'b000000, 6'd0);
      s[1] = mk(1'b0, 1'b1, 3'd2, 1'b1, 32'h5000, 4'd2, 4'd0, 4'd0, 32'h5000, 6'd0, 6'b000000, 6'd0);
      s[2] = mk(1'b0, 1'b0, 3'd0, 1'b0, 32'h0,    4'd0, 4'd0, 4'd0, 32'h5000, 6'd0, 6'b000000, 6'd0);
      s[3] = mk(1'b0, 1'b0, 3'd0, 1'b0, 32'h0,    4'd0, 4'd0, 4'd0, 32'h100,  6'd0, 6'b000000, 6'd0);
      s[4] = mk(1'b0, 1'b0, 3'd0, 1'b0, 32'h0,    4'd0, 4'd0, 4'd0, 32'h5000, 6'd0, 6'b000100, 6'd0);
      s[5] = mk(1'b0, 1'b0, 3'd0, 1'b0, 32'h0,    4'd0, 4'd0, 4'd0, 32'h100,  6'd0, 6'b000100, 6'd0);
      s[6] = mk(1'b0, 1'b0, 3'd0, 1'b0, 32'h0,    4'd0, 4'd0, 4'd0, 32'h100,  6'd0, 6'b000000, 6'd0);
      for (int i = 0; i < 7; i++) apply("wrprio", i, s[i]);
    end

`ifdef IRQ_INJ_ACK_EN
    // ack on the third high cycle of a len-10 pulse ends it as a counted fire.
    begin
      vec_t a[7];
      a[0] = mk(1'b1, 1'b0, 3'd0, 1'b0, 32'h0,    4'd0,  4'd0, 4'd0, 32'h100,  6'd0,      6'b000000, 6'b000000);
      a[1] = mk(1'b0, 1'b1, 3'd0, 1'b1, 32'h3024, 4'd10, 4'd0, 4'd1, 32'h100,  6'b000001, 6'b000000, 6'b000000);
      a[2] = mk(1'b0, 1'b0, 3'd0, 1'b0, 32'h0,    4'd0,  4'd0, 4'd0, 32'h3024, 6'd0,      6'b000001, 6'b000000);
      a[3] = mk(1'b0, 1'b0, 3'd0, 1'b0, 32'h0,    4'd0,  4'd0, 4'd0, 32'h100,  6'd0,      6'b000001, 6'b000000);
      a[4] = mk(1'b0, 1'b0, 3'd0, 1'b0, 32'h0,    4'd0,  4'd0, 4'd0, 32'h100,  6'd0,      6'b000001, 6'b000000);
      a[5] = mk(1'b0, 1'b0, 3'd0, 1'b0, 32'h0,    4'd0,  4'd0, 4'd0, 32'h100,  6'b000001, 6'b000000, 6'b000001);
      a[6] = mk(1'b0, 1'b0, 3'd0, 1'b0, 32'h0,    4'd0,  4'd0, 4'd0, 32'h3024, 6'd0,      6'b000000, 6'b000001);
      for (int i = 0; i < 7; i++) apply("ack", i, a[i]);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_inject_gen.md
# irq_inject_gen

Multi-channel, synthesizable interrupt stimulus generator for the P7 pipelined MIPS test environment. Each channel watches the CPU's macroscopic PC (`addr`). When the PC reaches a programmed trigger address, the channel drives its bit of the external interrupt vector (HWInt) high for a programmed number of cycles. A programmable delay, a fire-count limit and an optional acknowledge input are supported. The block sits between the `mips` top-level `addr` output and its interrupt inputs, so benches can inject exceptions-under-interrupt scenarios without hand-written negedge processes.

## Interface
- `CH`, 6 — number of channels (1..8); one irq bit per channel
- `ADDR_W`, 32 — PC and trigger-address width
- `LEN_W`, 4 — pulse-length field width
- `DLY_W`, 4 — match-to-assert delay field width
- `CNT_W`, 4 — fire-limit field width

- `clk` in 1 — clock; all state updates on the rising edge
- `reset` in 1 — reset, synchronous, active-high
- `pc_in` in ADDR_W — macroscopic PC from the CPU
- `cfg_we` in 1 — configuration write strobe
- `cfg_ch` in 3 — channel index for the write; values ≥ CH are ignored
- `cfg_en` in 1 — channel enable
- `cfg_pc` in ADDR_W — trigger address
- `cfg_len` in LEN_W — pulse length in cycles; 0 is treated as 1
- `cfg_dly` in DLY_W — cycles between match and assert
- `cfg_lim` in CNT_W — maximum fires; 0 means unlimited
- `irq_ack` in CH — per-channel acknowledge; present only with `IRQ_INJ_ACK_EN`
- `irq_o` out CH — interrupt vector to the CPU
- `irq_any_o` out 1 — OR of `irq_o`
- `done_o` out CH — channel has exhausted its fire limit

## Operation
- Per-channel registers: trig, len, dly, lim, fire counter (CNT_W), timer (max(LEN_W, DLY_W)), prev_match, and a state register.
- States: IDLE, ARMED, DELAY, ASSERT, DONE.
- A match is `pc_in == trig` this cycle AND prev_match == 0. This is an edge qualification, so a PC stalled on the trigger fires only once. prev_match updates every cycle in every state.
- IDLE: `irq_o` = 0. The channel leaves IDLE only through a config write with `cfg_en` = 1.
- ARMED → DELAY on a match when dly ≠ 0 (timer = dly − 1).
- ARMED → ASSERT on a match when dly = 0 (timer = eff_len − 1).
- DELAY: the timer counts down. At 0 the channel goes to ASSERT and reloads timer = eff_len − 1. Matches are ignored.
- ASSERT: `irq_o[i]` = 1. The timer counts down. At 0 the channel increments the fire counter, then:
  - goes to DONE if lim ≠ 0 and the new count == lim;
  - otherwise returns to ARMED.
  - Matches are ignored while in ASSERT.
- DONE: `irq_o[i]` = 0, `done_o[i]` = 1. The channel stays in DONE until the next config write to it.
- Config write to channel i:
  - loads all fields;
  - clears the fire counter and timer;
  - next state is ARMED if `cfg_en`, else IDLE;
  - `irq_o[i]` drops on the next edge even if the channel was in ASSERT.
  - A write takes priority over a same-cycle match or timer expiry on that channel. Other channels are unaffected.
- The fire counter saturates and never wraps. Unlimited mode (lim = 0) never enters DONE.

## Timing
- Reset: all states IDLE, all fields and counters 0, `irq_o` = 0, `irq_any_o` = 0, `done_o` = 0, prev_match = 0.
- Match sampled at edge t with dly = 0: `irq_o[i]` is high for cycles t+1 … t+eff_len.
- Match sampled at edge t with dly = D: `irq_o[i]` is high for cycles t+1+D … t+D+eff_len.
- All outputs are registered, with no combinational path from `pc_in` to `irq_o`. `irq_any_o` is the OR of the registered bits.
- Reset asserted mid-pulse: `irq_o` is 0 on the next edge.
- A config write at edge t: the new settings apply from edge t+1. A match can first be recognised at edge t+1.

## Configuration
- `IRQ_INJ_ACK_EN` defined:
  - the `irq_ack` port exists;
  - in ASSERT, `irq_ack[i]` = 1 ends the pulse at that edge, counting it as a fire exactly as a timer expiry would;
  - ack in any other state is ignored;
  - ack and timer expiry on the same edge count as one fire.
- Not defined: there is no `irq_ack` port, and pulses end only by timer expiry or config write.

## Test plan
- ch0 configured with trig 0x3024, len 6, dly 0, lim 1; PC reaches 0x3024 at edge t → `irq_o[0]` high for t+1..t+6, low afterwards; `done_o[0]` = 1 from t+7; a later visit to 0x3024 produces no pulse.
- ch1 configured with trig 0x4198, len 2, dly 3, lim 0; PC stalls on 0x4198 for 5 cycles, then leaves and returns → exactly two pulses, each 2 cycles long, each starting 4 cycles after its qualifying match.
- ch2 configured with len 0 → the pulse is 1 cycle. Config write to ch2 mid-pulse with `cfg_en` = 0 → irq drops next cycle and the channel stays IDLE.
- ch0 and ch3 both configured with trig 0x3000, len 3; PC hits 0x3000 → `irq_o` = 6'b001001 for 3 cycles and `irq_any_o` matches. Write with `cfg_ch` = 7 → no state change.
- Reset asserted during ASSERT of ch4 → `irq_o`, `done_o` = 0 next edge and all channels IDLE.
- With `IRQ_INJ_ACK_EN`: len 10 and `irq_ack[0]` at the 3rd high cycle → the pulse is 3 cycles; with lim 1, `done_o[0]` = 1 next cycle.
